// File: rtl/char_pkg.sv
// Shared definitions for the characterisation chain: sweep state encoding,
// meter sample width, and default window/split constants used by meter and host map.
package char_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SETTLE,
    ST_DISCARD,
    ST_MEASURE,
    ST_WRITE,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam int VPP_W = 12;
  localparam logic [VPP_W-1:0] VPP_TIMEOUT = 12'hFFF;

  localparam int unsigned TIMES_LOW_DEF  = 200;
  localparam int unsigned TIMES_HIGH_DEF = 2000;
  localparam int unsigned FREQ_SPLIT_DEF = 100000;

  // Low frequencies get the short window, everything at or above the split the long one.
  function automatic logic [31:0] sel_times(input logic [31:0] freq,
                                            input logic [31:0] split,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    return (freq < split) ? lo : hi;
  endfunction

endpackage

// File: rtl/vpp_sweep_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Load has priority over decrement; the count stops at zero.
module vpp_sweep_timer (
  input  logic        clk_sample,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] load_val,
  output logic        tc
);

  logic [31:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - 32'd1;
  end

  always_ff @(posedge clk_sample) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/vpp_sweep_ctrl.sv
// Frequency sweep sequencer: per point sets frequency and meter window, settles,
// drops the first meter window, records the second and tracks the sweep peak.
module vpp_sweep_ctrl
  import char_pkg::*;
#(
  parameter int unsigned N_POINTS      = 16,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned FREQ_SPLIT    = FREQ_SPLIT_DEF,
  parameter int unsigned TIMES_LOW     = TIMES_LOW_DEF,
  parameter int unsigned TIMES_HIGH    = TIMES_HIGH_DEF,
  parameter int unsigned WDOG_CYCLES   = 1000000
) (
  input  logic             clk_sample,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      f_start,
  input  logic [31:0]      f_step,
  output logic [31:0]      freq_out,
  output logic             freq_valid,
  output logic [31:0]      times_out,
  input  logic [VPP_W-1:0] vpp_in,
  input  logic             vpp_found_in,
  output logic             res_wr_en,
  output logic [7:0]       res_addr,
  output logic [VPP_W-1:0] res_vpp,
  output logic [31:0]      res_freq,
  output logic [VPP_W-1:0] peak_vpp,
  output logic [7:0]       peak_idx,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam logic [31:0] SETTLE_LD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] WDOG_LD   = 32'(WDOG_CYCLES - 1);
  localparam logic [31:0] SPLIT     = 32'(FREQ_SPLIT);
  localparam logic [31:0] T_LOW     = 32'(TIMES_LOW);
  localparam logic [31:0] T_HIGH    = 32'(TIMES_HIGH);
  localparam logic [7:0]  LAST_IDX  = 8'(N_POINTS - 1);

  state_e            state_d, state_q;
  logic [31:0]       freq_d, freq_q, step_d, step_q;
  logic [7:0]        idx_d, idx_q;
  logic [31:0]       freq_out_d, freq_out_q, times_out_d, times_out_q;
  logic              freq_valid_d, freq_valid_q;
  logic              res_wr_en_d, res_wr_en_q;
  logic [7:0]        res_addr_d, res_addr_q, peak_idx_d, peak_idx_q;
  logic [VPP_W-1:0]  res_vpp_d, res_vpp_q, peak_vpp_d, peak_vpp_q;
  logic [31:0]       res_freq_d, res_freq_q;
  logic              pt_to_d, pt_to_q;
  logic              busy_d, busy_q, done_d, done_q, timeout_d, timeout_q;
  logic              settle_ld, settle_tc, wdog_ld, wdog_tc;
  logic              cap, cap_to;

  vpp_sweep_timer u_settle (
    .clk_sample (clk_sample),
    .rst        (rst),
    .load       (settle_ld),
    .en         (state_q == ST_SETTLE),
    .load_val   (SETTLE_LD),
    .tc         (settle_tc)
  );

  vpp_sweep_timer u_wdog (
    .clk_sample (clk_sample),
    .rst        (rst),
    .load       (wdog_ld),
    .en         ((state_q == ST_DISCARD) || (state_q == ST_MEASURE)),
    .load_val   (WDOG_LD),
    .tc         (wdog_tc)
  );

  always_comb begin
    state_d      = state_q;
    freq_d       = freq_q;
    step_d       = step_q;
    idx_d        = idx_q;
    freq_out_d   = freq_out_q;
    freq_valid_d = 1'b0;
    times_out_d  = times_out_q;
    res_wr_en_d  = 1'b0;
    res_addr_d   = res_addr_q;
    res_vpp_d    = res_vpp_q;
    res_freq_d   = res_freq_q;
    pt_to_d      = pt_to_q;
    peak_vpp_d   = peak_vpp_q;
    peak_idx_d   = peak_idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    timeout_d    = timeout_q;
    settle_ld    = 1'b0;
    wdog_ld      = 1'b0;
    cap          = 1'b0;
    cap_to       = 1'b0;

    case (state_q)
      ST_IDLE: if (start) begin
        freq_d     = f_start;
        step_d     = f_step;
        idx_d      = '0;
        peak_vpp_d = '0;
        peak_idx_d = '0;
        timeout_d  = 1'b0;
        busy_d     = 1'b1;
        state_d    = ST_SETUP;
      end
      ST_SETUP: begin
        freq_out_d   = freq_q;
        freq_valid_d = 1'b1;
        times_out_d  = sel_times(freq_q, SPLIT, T_LOW, T_HIGH);
        settle_ld    = 1'b1;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: if (settle_tc) begin
        wdog_ld = 1'b1;
        state_d = ST_DISCARD;
      end
      // A found pulse takes priority over a watchdog expiry in the same cycle.
      ST_DISCARD: begin
        if (vpp_found_in) begin
          wdog_ld = 1'b1;
          state_d = ST_MEASURE;
        end else if (wdog_tc) begin
          cap    = 1'b1;
          cap_to = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (vpp_found_in)  cap = 1'b1;
        else if (wdog_tc) begin
          cap    = 1'b1;
          cap_to = 1'b1;
        end
      end
      ST_WRITE: begin
        if (!pt_to_q && (res_vpp_q > peak_vpp_q)) begin
          peak_vpp_d = res_vpp_q;
          peak_idx_d = res_addr_q;
        end
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          freq_d  = freq_q + step_q;
          state_d = ST_SETUP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (cap) begin
      res_wr_en_d = 1'b1;
      res_addr_d  = idx_q;
      res_freq_d  = freq_out_q;
      res_vpp_d   = cap_to ? VPP_TIMEOUT : vpp_in;
      pt_to_d     = cap_to;
      timeout_d   = timeout_q | cap_to;
      state_d     = ST_WRITE;
    end
  end

  always_ff @(posedge clk_sample) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      freq_q       <= '0;
      step_q       <= '0;
      idx_q        <= '0;
      freq_out_q   <= '0;
      freq_valid_q <= 1'b0;
      times_out_q  <= T_LOW;
      res_wr_en_q  <= 1'b0;
      res_addr_q   <= '0;
      res_vpp_q    <= '0;
      res_freq_q   <= '0;
      pt_to_q      <= 1'b0;
      peak_vpp_q   <= '0;
      peak_idx_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      freq_q       <= freq_d;
      step_q       <= step_d;
      idx_q        <= idx_d;
      freq_out_q   <= freq_out_d;
      freq_valid_q <= freq_valid_d;
      times_out_q  <= times_out_d;
      res_wr_en_q  <= res_wr_en_d;
      res_addr_q   <= res_addr_d;
      res_vpp_q    <= res_vpp_d;
      res_freq_q   <= res_freq_d;
      pt_to_q      <= pt_to_d;
      peak_vpp_q   <= peak_vpp_d;
      peak_idx_q   <= peak_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign freq_out   = freq_out_q;
  assign freq_valid = freq_valid_q;
  assign times_out  = times_out_q;
  assign res_wr_en  = res_wr_en_q;
  assign res_addr   = res_addr_q;
  assign res_vpp    = res_vpp_q;
  assign res_freq   = res_freq_q;
  assign peak_vpp   = peak_vpp_q;
  assign peak_idx   = peak_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_vpp_sweep_ctrl.sv
// Bench for vpp_sweep_ctrl: a behavioural Vpp meter drives found pulses per window,
// and an expected-result table built from the sweep rules is compared with the writes.
module tb_vpp_sweep_ctrl;

  localparam int NP     = 4;
  localparam int SETTLE = 10;
  localparam int T_LO   = 20;
  localparam int T_HI   = 50;
  localparam int WDOG   = 200;
  localparam logic [31:0] SPLIT = 32'd100000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] f_start = '0, f_step = '0;
  logic [11:0] vpp_in = '0;
  logic        vpp_found_in = 1'b0;
  logic [31:0] freq_out, times_out, res_freq;
  logic        freq_valid, res_wr_en, busy, done, timeout;
  logic [7:0]  res_addr, peak_idx;
  logic [11:0] res_vpp, peak_vpp;

  vpp_sweep_ctrl #(
    .N_POINTS(NP), .SETTLE_CYCLES(SETTLE), .FREQ_SPLIT(100000),
    .TIMES_LOW(T_LO), .TIMES_HIGH(T_HI), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk_sample(clk), .rst(rst), .start(start), .f_start(f_start), .f_step(f_step),
    .freq_out(freq_out), .freq_valid(freq_valid), .times_out(times_out),
    .vpp_in(vpp_in), .vpp_found_in(vpp_found_in), .res_wr_en(res_wr_en),
    .res_addr(res_addr), .res_vpp(res_vpp), .res_freq(res_freq),
    .peak_vpp(peak_vpp), .peak_idx(peak_idx), .busy(busy), .done(done),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [11:0] tgt[NP];
  bit          silent[NP];
  bit          glitch[NP];
  bit          meter_en = 1'b0;
  int          pt = -1;

  logic [7:0]  wq_addr[$];
  logic [11:0] wq_vpp[$];
  logic [31:0] wq_freq[$];
  logic [31:0] fv_times[$];
  int          done_cnt = 0;

  logic [31:0] e_freq[NP];
  logic [31:0] e_times[NP];
  logic [11:0] e_vpp[NP];
  logic [11:0] e_pk;
  logic [7:0]  e_pidx;
  bit          e_to;

  // Meter: window restarts with each new frequency; first window after the change
  // carries a bogus 4000, later ones the point's target. Optional glitch on the last settle cycle.
  initial begin
    int since, win, period;
    since = 0; win = 0;
    forever begin
      @(negedge clk);
      vpp_found_in = 1'b0;
      if (meter_en && !rst) begin
        if (freq_valid) begin
          pt++; since = 0; win = 0;
        end else since++;
        if (pt >= 0 && pt < NP) begin
          period = int'(times_out) + 1;
          if (glitch[pt] && since == SETTLE - 1) begin
            vpp_found_in = 1'b1; vpp_in = 12'd4000;
          end
          if (!silent[pt] && since > 0 && (since % period) == 0) begin
            vpp_found_in = 1'b1;
            vpp_in = (win == 0) ? 12'd4000 : tgt[pt];
            win++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (res_wr_en) begin
        wq_addr.push_back(res_addr);
        wq_vpp.push_back(res_vpp);
        wq_freq.push_back(res_freq);
      end
      if (freq_valid) fv_times.push_back(times_out);
      if (done) done_cnt++;
    end
  end

  task automatic build_model(input logic [31:0] fs, input logic [31:0] fst);
    e_pk = '0; e_pidx = '0; e_to = 1'b0;
    for (int i = 0; i < NP; i++) begin
      e_freq[i]  = fs + 32'(i) * fst;
      e_times[i] = (e_freq[i] < SPLIT) ? 32'(T_LO) : 32'(T_HI);
      e_vpp[i]   = silent[i] ? 12'hFFF : tgt[i];
      if (silent[i]) e_to = 1'b1;
      else if (tgt[i] > e_pk) begin
        e_pk = tgt[i]; e_pidx = 8'(i);
      end
    end
  endtask

  task automatic set_points(input bit rnd_silent, input bit rnd_glitch);
    for (int i = 0; i < NP; i++) begin
      tgt[i]    = 12'($urandom_range(3999, 1));
      silent[i] = rnd_silent ? ($urandom_range(3, 0) == 0) : 1'b0;
      glitch[i] = rnd_glitch ? 1'($urandom_range(1, 0)) : 1'b0;
    end
  endtask

  task automatic do_start(input logic [31:0] fs, input logic [31:0] fst);
    @(negedge clk);
    wq_addr.delete(); wq_vpp.delete(); wq_freq.delete(); fv_times.delete();
    pt = -1; meter_en = 1'b1;
    f_start = fs; f_step = fst; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int d0;
    d0 = done_cnt; ok = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({freq_out, times_out, freq_valid, res_wr_en, busy, done, timeout, res_addr,
         res_vpp, res_freq, peak_vpp, peak_idx} !==
        {32'd0, 32'(T_LO), 5'b0, 8'd0, 12'd0, 32'd0, 12'd0, 8'd0}) begin
      bad++;
      $display("FAIL reset_outputs: fo=%0h to=%0h fv=%0b we=%0b busy=%0b done=%0b tmo=%0b pk=%0h",
               freq_out, times_out, freq_valid, res_wr_en, busy, done, timeout, peak_vpp);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int d0;
    for (int i = 0; i < NP; i++) begin
      tgt[i] = 12'(100 + i); silent[i] = 1'b0; glitch[i] = 1'b0;
    end
    build_model(32'd1000, 32'd1000);
    d0 = done_cnt;
    do_start(32'd1000, 32'd1000);
    total++;
    if (busy !== 1'b1 || freq_valid !== 1'b0) begin
      bad++; $display("FAIL start_latency: busy=%0b fv=%0b want 1/0", busy, freq_valid);
    end
    @(negedge clk);
    total++;
    if (freq_valid !== 1'b1 || freq_out !== 32'd1000) begin
      bad++; $display("FAIL first_setup: fv=%0b fo=%0d want 1/1000", freq_valid, freq_out);
    end
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_done_wait: got no done want done"); end
    total++;
    if (wq_addr.size() != NP) begin
      bad++; $display("FAIL basic_nwrites: got %0d want %0d", wq_addr.size(), NP);
    end else begin
      for (int i = 0; i < NP; i++) begin
        total++;
        if (wq_addr[i] !== 8'(i) || wq_freq[i] !== e_freq[i] || wq_vpp[i] !== e_vpp[i]) begin
          bad++;
          $display("FAIL basic_write%0d: got a=%0d f=%0d v=%0d want a=%0d f=%0d v=%0d",
                   i, wq_addr[i], wq_freq[i], wq_vpp[i], i, e_freq[i], e_vpp[i]);
        end
      end
    end
    repeat (20) @(negedge clk);
    total++;
    if (peak_idx !== 8'd3 || peak_vpp !== 12'd103 || timeout !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_peak: got idx=%0d vpp=%0d tmo=%0b busy=%0b want 3/103/0/0",
                      peak_idx, peak_vpp, timeout, busy);
    end
    total++;
    if (done_cnt != d0 + 1) begin
      bad++; $display("FAIL basic_done_once: got %0d pulses want 1", done_cnt - d0);
    end
  endtask

  task automatic test_times();
    bit ok;
    set_points(1'b0, 1'b0);
    build_model(32'd99000, 32'd1000);
    do_start(32'd99000, 32'd1000);
    wait_done(ok);
    total++;
    if (!ok || fv_times.size() != NP) begin
      bad++; $display("FAIL times_count: got done=%0b n=%0d want 1/%0d", ok, fv_times.size(), NP);
    end else begin
      for (int i = 0; i < NP; i++) begin
        total++;
        if (fv_times[i] !== e_times[i]) begin
          bad++; $display("FAIL times_pt%0d: got %0d want %0d", i, fv_times[i], e_times[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    set_points(1'b0, 1'b0);
    silent[1] = 1'b1;
    tgt[1] = 12'd3999;
    build_model(32'd2000, 32'd500);
    do_start(32'd2000, 32'd500);
    wait_done(ok);
    total++;
    if (!ok || wq_vpp.size() != NP) begin
      bad++; $display("FAIL tmo_complete: got done=%0b n=%0d want 1/%0d", ok, wq_vpp.size(), NP);
    end else begin
      total++;
      if (wq_addr[1] !== 8'd1 || wq_vpp[1] !== 12'hFFF) begin
        bad++; $display("FAIL tmo_code: got a=%0d v=%0h want 1/fff", wq_addr[1], wq_vpp[1]);
      end
      for (int i = 0; i < NP; i++) begin
        total++;
        if (wq_vpp[i] !== e_vpp[i]) begin
          bad++; $display("FAIL tmo_write%0d: got %0h want %0h", i, wq_vpp[i], e_vpp[i]);
        end
      end
    end
    total++;
    if (timeout !== 1'b1 || peak_vpp !== e_pk || peak_idx !== e_pidx) begin
      bad++; $display("FAIL tmo_peak: got tmo=%0b pk=%0d idx=%0d want 1/%0d/%0d",
                      timeout, peak_vpp, peak_idx, e_pk, e_pidx);
    end
  endtask

  task automatic test_settle_glitch();
    bit ok;
    set_points(1'b0, 1'b0);
    for (int i = 0; i < NP; i++) glitch[i] = 1'b1;
    build_model(32'd150000, 32'd7);
    do_start(32'd150000, 32'd7);
    wait_done(ok);
    total++;
    if (!ok || wq_vpp.size() != NP) begin
      bad++; $display("FAIL glitch_complete: got done=%0b n=%0d want 1/%0d", ok, wq_vpp.size(), NP);
    end else begin
      for (int i = 0; i < NP; i++) begin
        total++;
        if (wq_vpp[i] !== e_vpp[i]) begin
          bad++; $display("FAIL glitch_write%0d: got %0d want %0d", i, wq_vpp[i], e_vpp[i]);
        end
      end
    end
  endtask

  task automatic test_wrap_tie();
    bit ok;
    set_points(1'b0, 1'b0);
    tgt[0] = 12'($urandom_range(499, 1));
    tgt[1] = 12'd500;
    tgt[2] = 12'd500;
    tgt[3] = 12'($urandom_range(499, 1));
    build_model(32'hFFFF_FFFF, 32'd2);
    do_start(32'hFFFF_FFFF, 32'd2);
    wait_done(ok);
    total++;
    if (!ok || wq_freq.size() != NP) begin
      bad++; $display("FAIL wrap_complete: got done=%0b n=%0d want 1/%0d", ok, wq_freq.size(), NP);
    end else begin
      total++;
      if (wq_freq[1] !== 32'd1) begin
        bad++; $display("FAIL wrap_freq1: got %0h want 1", wq_freq[1]);
      end
      for (int i = 0; i < NP; i++) begin
        total++;
        if (wq_freq[i] !== e_freq[i] || wq_vpp[i] !== e_vpp[i]) begin
          bad++; $display("FAIL wrap_write%0d: got f=%0h v=%0d want f=%0h v=%0d",
                          i, wq_freq[i], wq_vpp[i], e_freq[i], e_vpp[i]);
        end
      end
    end
    total++;
    if (peak_idx !== 8'd1 || peak_vpp !== 12'd500) begin
      bad++; $display("FAIL tie_peak: got idx=%0d vpp=%0d want 1/500", peak_idx, peak_vpp);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] fs, fst;
    for (int r = 0; r < 3; r++) begin
      set_points(1'b1, 1'b1);
      fs  = 32'($urandom_range(120000, 80000));
      fst = 32'($urandom_range(20000, 0));
      build_model(fs, fst);
      do_start(fs, fst);
      wait_done(ok);
      total++;
      if (!ok || wq_vpp.size() != NP || fv_times.size() != NP) begin
        bad++; $display("FAIL rand%0d_complete: got done=%0b n=%0d want 1/%0d", r, ok, wq_vpp.size(), NP);
      end else begin
        for (int i = 0; i < NP; i++) begin
          total++;
          if (wq_addr[i] !== 8'(i) || wq_freq[i] !== e_freq[i] || wq_vpp[i] !== e_vpp[i] ||
              fv_times[i] !== e_times[i]) begin
            bad++;
            $display("FAIL rand%0d_pt%0d: got a=%0d f=%0d v=%0h t=%0d want f=%0d v=%0h t=%0d",
                     r, i, wq_addr[i], wq_freq[i], wq_vpp[i], fv_times[i], e_freq[i], e_vpp[i], e_times[i]);
          end
        end
      end
      total++;
      if (peak_vpp !== e_pk || peak_idx !== e_pidx || timeout !== e_to) begin
        bad++; $display("FAIL rand%0d_peak: got pk=%0d idx=%0d tmo=%0b want %0d/%0d/%0b",
                        r, peak_vpp, peak_idx, timeout, e_pk, e_pidx, e_to);
      end
    end
  endtask

  task automatic test_busy_rst();
    bit ok;
    int d0;
    set_points(1'b0, 1'b0);
    d0 = done_cnt;
    do_start(32'd5000, 32'd100);
    repeat (5) @(negedge clk);
    f_start = 32'd77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || freq_out !== 32'd5000 || fv_times.size() != 1) begin
      bad++; $display("FAIL busy_start_ignored: got busy=%0b fo=%0d nfv=%0d want 1/5000/1",
                      busy, freq_out, fv_times.size());
    end
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (fv_times.size() >= 2) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || wq_freq.size() != 1 || wq_freq[0] !== 32'd5000) begin
      bad++; $display("FAIL busy_first_point: got ok=%0b n=%0d want 1/1 with freq 5000", ok, wq_freq.size());
    end
    // About 30 cycles into point 1: past the discarded window, inside MEASURE.
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    meter_en = 1'b0;
    total++;
    if ({freq_out, times_out, freq_valid, res_wr_en, busy, done, timeout, res_addr,
         res_vpp, res_freq, peak_vpp, peak_idx} !==
        {32'd0, 32'(T_LO), 5'b0, 8'd0, 12'd0, 32'd0, 12'd0, 8'd0}) begin
      bad++;
      $display("FAIL midsweep_reset: fo=%0h to=%0h fv=%0b we=%0b busy=%0b done=%0b rv=%0h rf=%0h",
               freq_out, times_out, freq_valid, res_wr_en, busy, done, res_vpp, res_freq);
    end
    repeat (300) @(negedge clk);
    total++;
    if (done_cnt != d0 || busy !== 1'b0 || wq_vpp.size() != 1) begin
      bad++; $display("FAIL rst_no_done: got done=%0d busy=%0b writes=%0d want 0/0/1",
                      done_cnt - d0, busy, wq_vpp.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_times();
    test_timeout();
    test_settle_glitch();
    test_wrap_tie();
    test_random();
    test_busy_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
